avmm_rr_arbiter: RTL and testbench
==================================

AVMM_RR_ARBITER -- requirements
Module: avmm_rr_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32: data width of all ports; byteenable width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: cycles allowed per transaction before the watchdog aborts it (minimum 2).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rstn  input  1  reset; asynchronous assertion, active-low.
REQ-006 rN_address  input  ADDR_WIDTH  requester N (N=0,1) address.
REQ-007 rN_read / rN_write  input  1 each  requester N command strobes.
REQ-008 rN_writedata  input  DATA_WIDTH  requester N write data.
REQ-009 rN_byteenable  input  DATA_WIDTH/8  requester N byte enables.
REQ-010 rN_waitrequest  output  1  requester N command stall.
REQ-011 rN_readdata  output  DATA_WIDTH  requester N read data.
REQ-012 rN_readdatavalid / rN_writeresponsevalid  output  1 each  requester N response strobes.
REQ-013 rN_response  output  2  requester N response code.
REQ-014 t_address, t_read, t_write, t_writedata, t_byteenable  output  as requester  shared target command.
REQ-015 t_waitrequest, t_readdata, t_readdatavalid, t_writeresponsevalid, t_response  input  as requester  shared target response.
REQ-016 grant  output  2  one-hot owner of the current transaction; 2'b00 when idle.
REQ-017 timeout_evt  output  1  one-cycle pulse when the watchdog aborts a transaction.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT_RSP. Exactly one transaction is outstanding at any time.
REQ-019 IDLE: a requester is requesting when its read or write is high. If any requester is requesting, register the owner and go to ISSUE on the next edge. Target command appears 1 cycle after the request is first seen.
REQ-020 Round-robin: when both request in the same cycle, grant the one not granted last. A lone requester is always granted.
REQ-021 ISSUE: t_* command mirrors the owner's inputs combinationally. Owner's rN_waitrequest equals t_waitrequest. When t_waitrequest is low, go to WAIT_RSP.
REQ-022 Non-owner rN_waitrequest is held high in every state. Both rN_waitrequest are high in IDLE.
REQ-023 Read and write asserted together by one requester is illegal. The arbiter forwards it as a read with t_write=0.
REQ-024 WAIT_RSP: t_read and t_write are low. t_readdata, t_readdatavalid, t_writeresponsevalid and t_response route combinationally to the owner only; the non-owner's valids are 0. The first valid received returns the FSM to IDLE and updates the last-granted pointer.
REQ-025 A response that arrives while no transaction is in WAIT_RSP is dropped. A response on the same cycle as the ISSUE acceptance is not expected and is dropped.
REQ-026 A zero-latency return (IDLE->ISSUE->WAIT_RSP->IDLE) is 3 cycles minimum. Back-to-back grants alternate between requesters when both hold requests.
REQ-027 Outputs that are not being driven are 0: t_* in IDLE, and the owner's readdata outside a valid.

Reset
REQ-028 rstn low immediately drives: state IDLE, grant 2'b00, timeout_evt 0, t_read/t_write 0, all rN_*valid 0, both rN_waitrequest 1, and the watchdog counter 0.
REQ-029 The last-granted pointer resets to requester 1, so requester 0 wins the first simultaneous request. A transaction in flight at reset is abandoned without a response.

Configuration
REQ-030 Macro AVMM_ARB_TIMEOUT_EN defined:
- A counter clears on entry to ISSUE and increments in ISSUE and WAIT_RSP.
- At TIMEOUT_CYCLES with no response, the FSM returns to IDLE and pulses timeout_evt.
- The owner receives its pending valid for one cycle with response 2'b10 and readdata 0.
- The pointer advances.
REQ-031 Macro undefined: no counter is built, timeout_evt is tied 0, and the arbiter waits indefinitely in ISSUE or WAIT_RSP.

Verification
REQ-032 r0 read of 0x10, target returns 0xA5A5_0001 one cycle after acceptance -> t_read high 1 cycle after request, r0_readdatavalid with 0xA5A5_0001, grant 2'b01, r1 sees no valid.
REQ-033 r0 and r1 both write continuously from reset -> grants in order r0, r1, r0, r1; t_writedata matches the owner each time.
REQ-034 Target holds t_waitrequest high 5 cycles during an r1 read -> r1_waitrequest high for those 5 cycles, t_address stable, single response delivered.
REQ-035 (AVMM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) target never responds to an r0 read -> after 16 cycles, timeout_evt pulse, r0_readdatavalid with response 2'b10 and readdata 0, then a late target valid in IDLE is dropped.
REQ-036 rstn asserted during WAIT_RSP -> outputs take reset values in the same cycle; after release, a simultaneous request is granted to r0.

Source files
------------

// File: rtl/avmm_rr_arbiter_if.sv
// Avalon-MM command/response bundle used for both requester ports and the shared target port.
interface avmm_rr_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    writeresponsevalid;
  logic [1:0]              response;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );
endinterface

// File: rtl/avmm_rr_arbiter.sv
// Two-requester round-robin Avalon-MM arbiter, one transaction outstanding at a time.
// Optional transaction watchdog is built when AVMM_ARB_TIMEOUT_EN is defined.
module avmm_rr_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  avmm_rr_arbiter_if.slave  r0,
  avmm_rr_arbiter_if.slave  r1,
  avmm_rr_arbiter_if.master t,
  output logic [1:0]        grant,
  output logic              timeout_evt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       rd_q, rd_d;
  logic [1:0] grant_q, grant_d;

  logic req0, req1, rsp_hit, expire, abort_rsp;

  logic [ADDR_WIDTH-1:0]   own_addr;
  logic [DATA_WIDTH-1:0]   own_wdata;
  logic [DATA_WIDTH/8-1:0] own_be;
  logic                    own_rd, own_wr;

  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_rdv, o_wrv;
  logic [1:0]            o_rsp;

  assign req0    = r0.read | r0.write;
  assign req1    = r1.read | r1.write;
  assign rsp_hit = (state_q == WAIT_RSP) && (t.readdatavalid || t.writeresponsevalid);

  assign own_addr  = owner_q ? r1.address    : r0.address;
  assign own_wdata = owner_q ? r1.writedata  : r0.writedata;
  assign own_be    = owner_q ? r1.byteenable : r0.byteenable;
  assign own_rd    = owner_q ? r1.read       : r0.read;
  assign own_wr    = owner_q ? r1.write      : r0.write;

`ifdef AVMM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tevt_q;

  // Counter sits at zero in IDLE, so it starts from zero on every ISSUE entry.
  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE) cnt_d = cnt_q + 1'b1;
  end

  assign expire = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !rsp_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tevt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tevt_q <= expire;
    end
  end

  assign abort_rsp   = tevt_q;
  assign timeout_evt = tevt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
  assign abort_rsp      = 1'b0;
  assign timeout_evt    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rd_d    = rd_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = (req0 && req1) ? ~last_q : req1;
          rd_d    = owner_d ? r1.read : r0.read;
          grant_d = owner_d ? 2'b10 : 2'b01;
          state_d = ISSUE;
        end
      end
      ISSUE:    if (!t.waitrequest) state_d = WAIT_RSP;
      WAIT_RSP: state_d = WAIT_RSP;
      default:  state_d = IDLE;
    endcase
    // A real response or a watchdog abort both close the transaction and rotate priority.
    if (rsp_hit || expire) begin
      state_d = IDLE;
      grant_d = 2'b00;
      last_d  = owner_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rd_q    <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;

  // Read wins when a requester illegally raises both strobes.
  always_comb begin
    t.address    = '0;
    t.read       = 1'b0;
    t.write      = 1'b0;
    t.writedata  = '0;
    t.byteenable = '0;
    if (state_q == ISSUE) begin
      t.address    = own_addr;
      t.read       = own_rd;
      t.write      = own_wr & ~own_rd;
      t.writedata  = own_wdata;
      t.byteenable = own_be;
    end
  end

  always_comb begin
    o_rdv   = 1'b0;
    o_wrv   = 1'b0;
    o_rdata = '0;
    o_rsp   = 2'b00;
    if (rsp_hit) begin
      o_rdv   = t.readdatavalid;
      o_wrv   = t.writeresponsevalid;
      o_rdata = t.readdatavalid ? t.readdata : '0;
      o_rsp   = t.response;
    end else if (abort_rsp) begin
      o_rdv = rd_q;
      o_wrv = ~rd_q;
      o_rsp = 2'b10;
    end
  end

  always_comb begin
    r0.waitrequest        = 1'b1;
    r1.waitrequest        = 1'b1;
    r0.readdata           = '0;
    r1.readdata           = '0;
    r0.readdatavalid      = 1'b0;
    r1.readdatavalid      = 1'b0;
    r0.writeresponsevalid = 1'b0;
    r1.writeresponsevalid = 1'b0;
    r0.response           = 2'b00;
    r1.response           = 2'b00;
    if (owner_q) begin
      if (state_q == ISSUE) r1.waitrequest = t.waitrequest;
      r1.readdata           = o_rdata;
      r1.readdatavalid      = o_rdv;
      r1.writeresponsevalid = o_wrv;
      r1.response           = o_rsp;
    end else begin
      if (state_q == ISSUE) r0.waitrequest = t.waitrequest;
      r0.readdata           = o_rdata;
      r0.readdatavalid      = o_rdv;
      r0.writeresponsevalid = o_wrv;
      r0.response           = o_rsp;
    end
  end

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// Self-checking bench for avmm_rr_arbiter: vector table for arbitration plus hand sequences
// for dropped responses, reset mid-transaction and (with AVMM_ARB_TIMEOUT_EN) the watchdog.
module tb_avmm_rr_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic [1:0] grant;
  logic       timeout_evt;

  always #5 clk = ~clk;

  avmm_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0_if ();
  avmm_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1_if ();
  avmm_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) t_if ();

  avmm_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .r0(r0_if), .r1(r1_if), .t(t_if),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  typedef struct {
    logic          owner;
    logic          is_read;
    logic [DW-1:0] data;
    logic [1:0]    rsp;
  } exp_t;

  // c0/c1: bit0 = read strobe, bit1 = write strobe
  typedef struct {
    logic [1:0]    c0;
    logic [1:0]    c1;
    int            wait_cyc;
    logic [DW-1:0] rdata;
    logic [1:0]    rsp;
    logic          exp_owner;
    logic          exp_tread;
    logic          exp_twrite;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   checks = 0;
  int   passed = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin : monitor
    logic v0, v1;
    exp_t e;
    v0 = r0_if.readdatavalid | r0_if.writeresponsevalid;
    v1 = r1_if.readdatavalid | r1_if.writeresponsevalid;
    if (v0 || v1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_valid", {62'd0, v1, v0}, 64'd0);
      end else begin
        e = sb.pop_front();
        check_output("rsp_owner", {62'd0, v1, v0}, e.owner ? 64'd2 : 64'd1);
        if (e.owner) begin
          check_output("rsp_kind", {62'd0, r1_if.readdatavalid, r1_if.writeresponsevalid}, e.is_read ? 64'd2 : 64'd1);
          check_output("rsp_data", 64'(r1_if.readdata), 64'(e.data));
          check_output("rsp_code", 64'(r1_if.response), 64'(e.rsp));
        end else begin
          check_output("rsp_kind", {62'd0, r0_if.readdatavalid, r0_if.writeresponsevalid}, e.is_read ? 64'd2 : 64'd1);
          check_output("rsp_data", 64'(r0_if.readdata), 64'(e.data));
          check_output("rsp_code", 64'(r0_if.response), 64'(e.rsp));
        end
      end
    end else begin
      check_output("quiet_readdata", {r1_if.readdata, r0_if.readdata}, 64'd0);
    end
  end

  task automatic apply_stimulus(input int idx, input vec_t v);
    logic [AW-1:0] a0, a1, oaddr;
    logic [DW-1:0] w0, w1, owdata;
    a0 = 32'h10 + 32'(idx * 4);
    a1 = 32'h8000_0000 + 32'(idx * 4);
    w0 = 32'h1000_0000 + 32'(idx);
    w1 = 32'h2000_0000 + 32'(idx);
    oaddr  = v.exp_owner ? a1 : a0;
    owdata = v.exp_owner ? w1 : w0;
    r0_if.read = v.c0[0]; r0_if.write = v.c0[1]; r0_if.address = a0; r0_if.writedata = w0; r0_if.byteenable = 4'hF;
    r1_if.read = v.c1[0]; r1_if.write = v.c1[1]; r1_if.address = a1; r1_if.writedata = w1; r1_if.byteenable = 4'h3;
    t_if.waitrequest = (v.wait_cyc > 0);
    @(negedge clk);
    check_output("idle_waitreq", {62'd0, r1_if.waitrequest, r0_if.waitrequest}, 64'd3);
    check_output("idle_grant", 64'(grant), 64'd0);
    check_output("idle_tcmd", {62'd0, t_if.read, t_if.write}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("issue_grant", 64'(grant), v.exp_owner ? 64'd2 : 64'd1);
    check_output("issue_tcmd", {62'd0, t_if.read, t_if.write}, {62'd0, v.exp_tread, v.exp_twrite});
    check_output("issue_taddr", 64'(t_if.address), 64'(oaddr));
    check_output("issue_twdata", 64'(t_if.writedata), 64'(owdata));
    check_output("issue_tbe", 64'(t_if.byteenable), v.exp_owner ? 64'h3 : 64'hF);
    for (int k = 0; k < v.wait_cyc; k++) begin
      check_output("stall_waitreq", {62'd0, r1_if.waitrequest, r0_if.waitrequest}, 64'd3);
      check_output("stall_taddr", 64'(t_if.address), 64'(oaddr));
      @(posedge clk); #1;
      if (k == v.wait_cyc - 1) t_if.waitrequest = 1'b0;
      @(negedge clk);
    end
    check_output("accept_waitreq", {62'd0, r1_if.waitrequest, r0_if.waitrequest}, v.exp_owner ? 64'd1 : 64'd2);
    @(posedge clk); #1;
    sb.push_back('{v.exp_owner, v.exp_tread, v.exp_tread ? v.rdata : 32'h0, v.rsp});
    t_if.readdata           = v.rdata;
    t_if.response           = v.rsp;
    t_if.readdatavalid      = v.exp_tread;
    t_if.writeresponsevalid = !v.exp_tread;
    @(negedge clk);
    check_output("wait_tcmd", {62'd0, t_if.read, t_if.write}, 64'd0);
    check_output("wait_grant", 64'(grant), v.exp_owner ? 64'd2 : 64'd1);
    @(posedge clk); #1;
    t_if.readdatavalid      = 1'b0;
    t_if.writeresponsevalid = 1'b0;
    t_if.response           = 2'b00;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin : main
    int found;
    r0_if.address = '0; r0_if.read = 0; r0_if.write = 0; r0_if.writedata = '0; r0_if.byteenable = '0;
    r1_if.address = '0; r1_if.read = 0; r1_if.write = 0; r1_if.writedata = '0; r1_if.byteenable = '0;
    t_if.waitrequest = 0; t_if.readdata = '0; t_if.readdatavalid = 0; t_if.writeresponsevalid = 0; t_if.response = 2'b00;

    vecs[0]  = '{2'b01, 2'b00, 0, 32'hA5A5_0001, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{2'b00, 2'b01, 5, 32'h5A5A_1111, 2'b00, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{2'b10, 2'b10, 0, 32'h0BAD_0002, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'b10, 2'b10, 1, 32'h0BAD_0003, 2'b01, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{2'b10, 2'b10, 0, 32'h0BAD_0004, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{2'b10, 2'b10, 0, 32'h0BAD_0005, 2'b11, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{2'b11, 2'b00, 0, 32'h1234_5678, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{2'b01, 2'b10, 0, 32'h0BAD_0007, 2'b00, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{2'b10, 2'b00, 2, 32'h0BAD_0008, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'b01, 2'b00, 0, 32'hCAFE_0009, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{2'b01, 2'b01, 0, 32'hBEEF_000A, 2'b10, 1'b1, 1'b1, 1'b0};

    #2 rstn = 1'b0;
    @(negedge clk);
    check_output("rst_grant", 64'(grant), 64'd0);
    check_output("rst_waitreq", {62'd0, r1_if.waitrequest, r0_if.waitrequest}, 64'd3);
    check_output("rst_tcmd", {62'd0, t_if.read, t_if.write}, 64'd0);
    check_output("rst_timeout", 64'(timeout_evt), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) apply_stimulus(i, vecs[i]);
    r0_if.read = 0; r0_if.write = 0; r1_if.read = 0; r1_if.write = 0;

    // Response while idle must not reach anyone.
    t_if.readdatavalid = 1'b1; t_if.readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_output("idle_drop", {62'd0, r1_if.readdatavalid, r0_if.readdatavalid}, 64'd0);
    @(posedge clk); #1;
    t_if.readdatavalid = 1'b0;

    // Response coinciding with the accepting ISSUE cycle is dropped; the real one follows.
    r0_if.write = 1'b1; r0_if.writedata = 32'h7777_0000; t_if.waitrequest = 1'b0;
    @(posedge clk); #1;
    t_if.writeresponsevalid = 1'b1; t_if.response = 2'b11;
    @(negedge clk);
    check_output("accept_drop", 64'(r0_if.writeresponsevalid), 64'd0);
    check_output("accept_grant", 64'(grant), 64'd1);
    @(posedge clk); #1;
    t_if.writeresponsevalid = 1'b0; r0_if.write = 1'b0;
    @(negedge clk);
    check_output("still_waiting", 64'(grant), 64'd1);
    @(posedge clk); #1;
    sb.push_back('{1'b0, 1'b0, 32'h0, 2'b01});
    t_if.writeresponsevalid = 1'b1; t_if.response = 2'b01;
    @(negedge clk);
    @(posedge clk); #1;
    t_if.writeresponsevalid = 1'b0; t_if.response = 2'b00;

    // Reset while waiting for r1's response; afterwards r0 must win a tie.
    r1_if.read = 1'b1; r1_if.address = 32'h444;
    @(posedge clk); #1;
    @(posedge clk); #1;
    r1_if.read = 1'b0;
    rstn = 1'b0;
    t_if.readdatavalid = 1'b1; t_if.readdata = 32'h0000_0777;
    #1;
    check_output("midrst_grant", 64'(grant), 64'd0);
    check_output("midrst_waitreq", {62'd0, r1_if.waitrequest, r0_if.waitrequest}, 64'd3);
    check_output("midrst_valid", {62'd0, r1_if.readdatavalid, r0_if.readdatavalid}, 64'd0);
    check_output("midrst_tcmd", {62'd0, t_if.read, t_if.write}, 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    t_if.readdatavalid = 1'b0;
    r0_if.read = 1'b1; r0_if.address = 32'h600;
    r1_if.read = 1'b1; r1_if.address = 32'h700;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("postrst_grant", 64'(grant), 64'd1);
    check_output("postrst_taddr", 64'(t_if.address), 64'h600);
    @(posedge clk); #1;
    r0_if.read = 1'b0; r1_if.read = 1'b0;
    sb.push_back('{1'b0, 1'b1, 32'h0BAD_F00D, 2'b00});
    t_if.readdatavalid = 1'b1; t_if.readdata = 32'h0BAD_F00D;
    @(negedge clk);
    @(posedge clk); #1;
    t_if.readdatavalid = 1'b0;

`ifdef AVMM_ARB_TIMEOUT_EN
    // Target never answers r0's read: abort after TMO cycles, then a late valid is ignored.
    sb.push_back('{1'b0, 1'b1, 32'h0, 2'b10});
    r0_if.read = 1'b1; r0_if.address = 32'h900;
    @(posedge clk); #1;
    found = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (timeout_evt && found < 0) found = n;
      @(posedge clk); #1;
      r0_if.read = 1'b0;
      if (found >= 0) break;
    end
    check_output("timeout_cycle", 64'(found), 64'(TMO));
    t_if.readdatavalid = 1'b1; t_if.readdata = 32'h1A7E_0000;
    @(negedge clk);
    check_output("timeout_pulse", 64'(timeout_evt), 64'd0);
    check_output("late_drop", {62'd0, r1_if.readdatavalid, r0_if.readdatavalid}, 64'd0);
    @(posedge clk); #1;
    t_if.readdatavalid = 1'b0;
`else
    found = 0;
`endif

    check_output("sb_drained", 64'(sb.size()), 64'(found - found));
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
